instr_info_done_arbiter: RTL and testbench

//  Shares one read port of the per-wavefront instruction-info table among the four

---
 rtl/instr_info_done_arbiter.sv | 171 +++++++++++++++++
 tb/tb_instr_info_done_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_info_done_arbiter.sv
// ---------------------------------------------------------------------------
// instr_info_done_arbiter
//
// Shares the single read port of the per-wavefront instruction-info table
// among four completion sources (0=vgpr_alu 1=vgpr_lsu 2=sgpr_alu 3=sgpr_lsu).
// Each source pushes done-wfids into a private FIFO. An arbiter pops one
// winner per cycle, drives its wfid to the table, and captures the returned
// entry with wfid and source id into a valid/ready output stage.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   req_valid     per-source done request
//   req_wfid      per-source wfid, source i at [i*WFID_W +: WFID_W]
//   req_ready     per-source FIFO not full (0 while in reset)
//   tbl_rd_wfid   combinational table read address (0 when no grant)
//   tbl_rd_data   combinational table data for tbl_rd_wfid
//   done_valid    output stage holds a result
//   done_ready    consumer accepts the result
//   done_wfid     wfid of the result
//   done_src      source index of the result
//   done_data     table entry captured at grant
//
// Configuration macro:
//   INSTR_INFO_ARB_FIXED_PRIO_EN  defined: fixed priority (source 0 highest),
//                                 no round-robin pointer.
//                                 undefined: round-robin arbitration.
// ---------------------------------------------------------------------------
module instr_info_done_arbiter #(
    parameter int WFID_W     = 6,
    parameter int INFO_W     = 64,
    parameter int FIFO_DEPTH = 4,
    parameter int NUM_REQ    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*WFID_W-1:0] req_wfid,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [WFID_W-1:0]         tbl_rd_wfid,
    input  logic [INFO_W-1:0]         tbl_rd_data,
    output logic                      done_valid,
    input  logic                      done_ready,
    output logic [WFID_W-1:0]         done_wfid,
    output logic [1:0]                done_src,
    output logic [INFO_W-1:0]         done_data
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WFID_W-1:0] mem    [NUM_REQ][FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr [NUM_REQ];
    logic [PTR_W-1:0]  wr_ptr [NUM_REQ];
    logic [CNT_W-1:0]  count  [NUM_REQ];

    logic [NUM_REQ-1:0] nonempty;
    logic [NUM_REQ-1:0] push;
    logic [NUM_REQ-1:0] pop;
    logic               adv;
    logic               grant;
    logic [1:0]         winner;
    logic [1:0]         start_idx;

`ifdef INSTR_INFO_ARB_FIXED_PRIO_EN
    assign start_idx = 2'd0;
`else
    logic [1:0] rr_ptr;
    assign start_idx = rr_ptr;
`endif

    // The output stage may take a new result when empty or being drained.
    assign adv = !done_valid || done_ready;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            // Ready deliberately ignores a same-cycle pop to keep the path short.
            req_ready[i] = !rst && (count[i] != CNT_W'(FIFO_DEPTH));
            nonempty[i]  = (count[i] != '0);
            push[i]      = req_valid[i] && req_ready[i];
        end
    end

    // Scan from start_idx upward (mod 4); first non-empty FIFO wins.
    always_comb begin
        // NOTE: every variable gets a default before any conditional assignment
        // so the block stays purely combinational and no latch is inferred.
        logic [1:0] idx;
        idx    = '0;
        grant  = 1'b0;
        winner = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = start_idx + k[1:0];
            if (!grant && nonempty[idx]) begin
                grant  = 1'b1;
                winner = idx;
            end
        end
        if (rst || !adv) begin
            grant = 1'b0;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            pop[i] = grant && (winner == i[1:0]);
        end
    end

    assign tbl_rd_wfid = grant ? mem[winner][rd_ptr[winner]] : '0;

    // NOTE: FIFO storage carries no reset; the counts alone define which
    // entries are live, so stale contents are never observed.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (push[i]) begin
                mem[i][wr_ptr[i]] <= req_wfid[i*WFID_W +: WFID_W];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (push[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                end
                // Simultaneous push and pop leaves the count unchanged.
                if (push[i] && !pop[i]) begin
                    count[i] <= count[i] + CNT_W'(1);
                end else if (!push[i] && pop[i]) begin
                    count[i] <= count[i] - CNT_W'(1);
                end
            end
        end
    end

    // Output stage; the payload holds when the stage drains without a new grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_valid <= 1'b0;
            done_wfid  <= '0;
            done_src   <= '0;
            done_data  <= '0;
`ifndef INSTR_INFO_ARB_FIXED_PRIO_EN
            rr_ptr     <= '0;
`endif
        end else if (grant) begin
            done_valid <= 1'b1;
            done_wfid  <= tbl_rd_wfid;
            done_src   <= winner;
            done_data  <= tbl_rd_data;
`ifndef INSTR_INFO_ARB_FIXED_PRIO_EN
            rr_ptr     <= winner + 2'd1;
`endif
        end else if (done_ready) begin
            done_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_info_done_arbiter.sv
// ---------------------------------------------------------------------------
// tb_instr_info_done_arbiter
//
// Directed scenarios (reset, single, round-robin, backpressure, full FIFO,
// mid-flight reset) followed by randomized traffic. A queue-based model of
// the arbiter is compared against every DUT output each cycle; a few literal
// expectations pin the model in the directed scenarios.
// ---------------------------------------------------------------------------
module tb_instr_info_done_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [23:0] req_wfid;
    logic [3:0]  req_ready;
    logic [5:0]  tbl_rd_wfid;
    logic [63:0] tbl_rd_data;
    logic        done_valid;
    logic        done_ready;
    logic [5:0]  done_wfid;
    logic [1:0]  done_src;
    logic [63:0] done_data;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Table stand-in: entry for address a is 0xA0 + a.
    assign tbl_rd_data = 64'hA0 + 64'(tbl_rd_wfid);

    instr_info_done_arbiter #(
        .WFID_W(6), .INFO_W(64), .FIFO_DEPTH(4), .NUM_REQ(4)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_wfid(req_wfid), .req_ready(req_ready),
        .tbl_rd_wfid(tbl_rd_wfid), .tbl_rd_data(tbl_rd_data),
        .done_valid(done_valid), .done_ready(done_ready),
        .done_wfid(done_wfid), .done_src(done_src), .done_data(done_data)
    );

    // ---------------- behavioural model ----------------
    logic [5:0]  q [4][$];
    int          m_rr = 0;
    logic        m_dv = 1'b0;
    logic [5:0]  m_wfid = '0;
    logic [1:0]  m_src = '0;
    logic [63:0] m_data = '0;

    function automatic int m_winner();
        for (int k = 0; k < 4; k++) begin
            if (q[(m_rr + k) % 4].size() > 0) return (m_rr + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_step();
        int w;
        bit ready [4];
        if (rst) begin
            for (int i = 0; i < 4; i++) q[i].delete();
            m_rr = 0; m_dv = 0; m_wfid = 0; m_src = 0; m_data = 0;
        end else begin
            for (int i = 0; i < 4; i++) ready[i] = (q[i].size() != 4);
            w = m_winner();
            if ((!m_dv || done_ready) && w >= 0) begin
                m_wfid = q[w].pop_front();
                m_src  = 2'(w);
                m_data = 64'hA0 + 64'(m_wfid);
                m_dv   = 1'b1;
`ifndef INSTR_INFO_ARB_FIXED_PRIO_EN
                m_rr   = (w + 1) % 4;
`endif
            end else if (done_ready) begin
                m_dv = 1'b0;
            end
            for (int i = 0; i < 4; i++) begin
                if (req_valid[i] && ready[i]) q[i].push_back(req_wfid[i*6 +: 6]);
            end
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic [3:0] e_ready;
        logic [5:0] e_tbl;
        int w;
        for (int i = 0; i < 4; i++) e_ready[i] = !rst && (q[i].size() != 4);
        w = m_winner();
        e_tbl = (!rst && (!m_dv || done_ready) && w >= 0) ? q[w][0] : 6'd0;
        check("req_ready",   64'(req_ready),   64'(e_ready));
        check("tbl_rd_wfid", 64'(tbl_rd_wfid), 64'(e_tbl));
        check("done_valid",  64'(done_valid),  64'(m_dv));
        check("done_wfid",   64'(done_wfid),   64'(m_wfid));
        check("done_src",    64'(done_src),    64'(m_src));
        check("done_data",   done_data,        m_data);
    endtask

    // One clock: drive, compare before the edge, advance model at the edge.
    task automatic cycle(input logic r, input logic [3:0] v, input logic [23:0] w, input logic dr);
        rst = r; req_valid = v; req_wfid = w; done_ready = dr;
        #1;
        compare_all();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle(input logic dr);
        cycle(1'b0, 4'h0, 24'h0, dr);
    endtask

    task automatic expect_done(input string name, input logic [5:0] w, input logic [1:0] s);
        check({name, "_valid"}, 64'(done_valid), 64'd1);
        check({name, "_wfid"},  64'(done_wfid),  64'(w));
        check({name, "_src"},   64'(done_src),   64'(s));
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_wfid = '0; done_ready = 1'b0;
        @(negedge clk);

        // T1: reset with all requests active
        for (int n = 0; n < 2; n++) begin
            cycle(1'b1, 4'hF, 24'($urandom), 1'b1);
            check("t1_ready", 64'(req_ready), 64'd0);
            check("t1_valid", 64'(done_valid), 64'd0);
            check("t1_data",  done_data, 64'd0);
        end
        idle(1'b1);
        check("t1_no_done", 64'(done_valid), 64'd0);

        // T2: single request from src1
        cycle(1'b0, 4'b0010, {6'd0, 6'd0, 6'd5, 6'd0}, 1'b1);
        check("t2_tbl", 64'(tbl_rd_wfid), 64'd5);
        idle(1'b1);
        expect_done("t2", 6'd5, 2'd1);
        check("t2_data", done_data, 64'hA5);
        idle(1'b1);
        check("t2_drop", 64'(done_valid), 64'd0);

        // T3: simultaneous pushes from a fresh pointer
        cycle(1'b1, 4'h0, 24'h0, 1'b1);
        cycle(1'b0, 4'hF, {6'd13, 6'd12, 6'd11, 6'd10}, 1'b1);
        for (int k = 0; k < 4; k++) begin
            idle(1'b1);
            expect_done("t3_rr", 6'(10 + k), 2'(k));
        end
        cycle(1'b0, 4'b1001, {6'd23, 6'd0, 6'd0, 6'd20}, 1'b1);
        idle(1'b1);
        expect_done("t3_a", 6'd20, 2'd0);
        idle(1'b1);
        expect_done("t3_b", 6'd23, 2'd3);
        idle(1'b1);

        // T4: backpressure with three queued
        cycle(1'b0, 4'b0111, {6'd0, 6'd32, 6'd31, 6'd30}, 1'b0);
        idle(1'b0);
        for (int n = 0; n < 5; n++) begin
            idle(1'b0);
            expect_done("t4_hold", 6'd30, 2'd0);
        end
        idle(1'b1);
        expect_done("t4_d1", 6'd31, 2'd1);
        idle(1'b1);
        expect_done("t4_d2", 6'd32, 2'd2);
        idle(1'b1);
        check("t4_empty", 64'(done_valid), 64'd0);

        // T5: fill src2 behind a stalled output stage
        cycle(1'b0, 4'b0001, {6'd0, 6'd0, 6'd0, 6'd40}, 1'b0);
        idle(1'b0);
        for (int n = 0; n < 5; n++) begin
            cycle(1'b0, 4'b0100, {6'd0, 6'(41 + n), 6'd0, 6'd0}, 1'b0);
            if (n == 3) check("t5_full", 64'(req_ready[2]), 64'd0);
        end
        expect_done("t5_stall", 6'd40, 2'd0);
        for (int n = 0; n < 4; n++) begin
            idle(1'b1);
            expect_done("t5_drain", 6'(41 + n), 2'd2);
        end
        idle(1'b1);
        check("t5_dropped", 64'(done_valid), 64'd0);

        // T6: reset while entries are queued and held
        cycle(1'b0, 4'b1011, {6'd53, 6'd0, 6'd51, 6'd50}, 1'b0);
        cycle(1'b0, 4'b0100, {6'd0, 6'd52, 6'd0, 6'd0}, 1'b0);
        check("t6_held", 64'(done_valid), 64'd1);
        cycle(1'b1, 4'h0, 24'h0, 1'b0);
        check("t6_valid", 64'(done_valid), 64'd0);
        for (int n = 0; n < 4; n++) begin
            idle(1'b1);
            check("t6_stale", 64'(done_valid), 64'd0);
        end

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            cycle(($urandom_range(0, 99) == 0), 4'($urandom), 24'($urandom),
                  ($urandom_range(0, 9) < 7));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
